// File: rtl/conv_pkg.sv
// Shared types and default geometry for the convolution window sequencer.
package conv_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StStream,
        StDrain,
        StDone
    } conv_state_e;

    localparam int unsigned DEF_IMAGE_WIDTH  = 28;
    localparam int unsigned DEF_IMAGE_HEIGHT = 28;
    localparam int unsigned DEF_KERNEL_WIDTH = 5;

    localparam int unsigned LB_DEPTH = DEF_IMAGE_WIDTH - DEF_KERNEL_WIDTH;
    localparam int unsigned NUM_WIN  = (DEF_IMAGE_WIDTH - DEF_KERNEL_WIDTH + 1)
                                     * (DEF_IMAGE_HEIGHT - DEF_KERNEL_WIDTH + 1);

endpackage

// File: rtl/raster_pos_counter.sv
// Raster-order column/row position counter with clear, enable and last-pixel flag.
module raster_pos_counter #(
    parameter int unsigned WIDTH  = 28,
    parameter int unsigned HEIGHT = 28,
    parameter int unsigned COL_W  = $clog2(WIDTH),
    parameter int unsigned ROW_W  = $clog2(HEIGHT)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [COL_W-1:0] o_col,
    output logic [ROW_W-1:0] o_row,
    output logic             o_last
);

    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    logic             w_col_last;
    logic             w_row_last;

    assign w_col_last = (r_col == COL_W'(WIDTH - 1));
    assign w_row_last = (r_row == ROW_W'(HEIGHT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_col <= '0;
            r_row <= '0;
        end else if (i_clr) begin
            r_col <= '0;
            r_row <= '0;
        end else if (i_en) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    assign o_col  = r_col;
    assign o_row  = r_row;
    assign o_last = w_col_last & w_row_last;

endmodule

// File: rtl/conv_window_ctrl.sv
// Frame sequencer for the convolution line buffers: pixel handshake, shift enable,
// window-valid flag with coordinates, and frame-done pulse.
module conv_window_ctrl
    import conv_pkg::*;
#(
    parameter int unsigned IMAGE_WIDTH  = DEF_IMAGE_WIDTH,
    parameter int unsigned IMAGE_HEIGHT = DEF_IMAGE_HEIGHT,
    parameter int unsigned KERNEL_WIDTH = DEF_KERNEL_WIDTH,
    parameter int unsigned COL_W        = $clog2(IMAGE_WIDTH),
    parameter int unsigned ROW_W        = $clog2(IMAGE_HEIGHT)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    output logic             o_busy,
    input  logic             i_pix_valid,
    output logic             o_pix_ready,
    output logic             o_shift_en,
    output logic             o_win_valid,
    input  logic             i_win_ready,
    output logic [ROW_W-1:0] o_win_row,
    output logic [COL_W-1:0] o_win_col,
    output logic             o_frame_done
);

    conv_state_e      r_state;
    conv_state_e      w_state_next;
    logic             w_pix_ready;
    logic             w_shift_en;
    logic             w_cnt_clr;
    logic             w_win_hit;
    logic             w_last;
    logic [COL_W-1:0] w_col;
    logic [ROW_W-1:0] w_row;
    logic             r_win_valid;
    logic [ROW_W-1:0] r_win_row;
    logic [COL_W-1:0] r_win_col;

    raster_pos_counter #(
        .WIDTH  (IMAGE_WIDTH),
        .HEIGHT (IMAGE_HEIGHT),
        .COL_W  (COL_W),
        .ROW_W  (ROW_W)
    ) u_pos (
        .clk    (clk),
        .reset  (reset),
        .i_clr  (w_cnt_clr),
        .i_en   (w_shift_en),
        .o_col  (w_col),
        .o_row  (w_row),
        .o_last (w_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Stall rather than skid: a held, unconsumed window blocks the next pixel.
    always_comb begin
        w_state_next = r_state;
        w_pix_ready  = 1'b0;
        w_cnt_clr    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_state_next = StStream;
                    w_cnt_clr    = 1'b1;
                end
            end
            StStream: begin
                w_pix_ready = ~r_win_valid | i_win_ready;
                if (w_pix_ready && i_pix_valid && w_last) begin
                    w_state_next = StDrain;
                end
            end
            StDrain: begin
                if (r_win_valid && i_win_ready) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    assign w_shift_en = w_pix_ready & i_pix_valid;

    // Only pixels with a full KxK footprint above-left of them close a window,
    // so windows never straddle a row boundary.
    assign w_win_hit = w_shift_en
                     && (w_row >= ROW_W'(KERNEL_WIDTH - 1))
                     && (w_col >= COL_W'(KERNEL_WIDTH - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_win_valid <= 1'b0;
            r_win_row   <= '0;
            r_win_col   <= '0;
        end else if (w_win_hit) begin
            r_win_valid <= 1'b1;
            r_win_row   <= w_row - ROW_W'(KERNEL_WIDTH - 1);
            r_win_col   <= w_col - COL_W'(KERNEL_WIDTH - 1);
        end else if (r_win_valid && i_win_ready) begin
            r_win_valid <= 1'b0;
        end
    end

    assign o_busy       = (r_state != StIdle);
    assign o_pix_ready  = w_pix_ready;
    assign o_shift_en   = w_shift_en;
    assign o_win_valid  = r_win_valid;
    assign o_win_row    = r_win_row;
    assign o_win_col    = r_win_col;
    assign o_frame_done = (r_state == StDone);

endmodule
